// File: rtl/qspi_flash_op_sequencer.sv
// Flash program/erase sequencer: WREN, then the operation, then RDSR polling
// until WIP clears or the poll limit is reached, one engine transaction per step.
module qspi_flash_op_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int POLL_MAX   = 1024,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_len,
  input  logic                  req_addr4b,
  output logic                  busy,
  output logic                  cmpl_valid,
  output logic [1:0]            cmpl_err,
  output logic [7:0]            cmpl_status,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic [7:0]            eng_opcode,
  output logic [1:0]            eng_cmd_lanes,
  output logic [1:0]            eng_addr_lanes,
  output logic [1:0]            eng_data_lanes,
  output logic [1:0]            eng_addr_bytes,
  output logic                  eng_dir,
  output logic [31:0]           eng_len,
  output logic [ADDR_WIDTH-1:0] eng_addr,
  input  logic [31:0]           eng_rx_data,
  input  logic                  eng_rx_wen,
  output logic [3:0]            dbg_state
);

  // Request handshake: a request is taken on a clock edge where
  // req_valid & req_ready are both high; req_ready is only ever high in IDLE.

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WREN_GO   = 4'd1,
    S_WREN_WAIT = 4'd2,
    S_OP_GO     = 4'd3,
    S_OP_WAIT   = 4'd4,
    S_GAP       = 4'd5,
    S_POLL_GO   = 4'd6,
    S_POLL_WAIT = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_PP4  = 8'h38;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_BE   = 8'hD8;
  localparam logic [7:0] OPC_CE   = 8'h60;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  localparam logic [1:0] LANE_X1  = 2'd0;
  localparam logic [1:0] LANE_X4  = 2'd2;
  localparam logic [1:0] AB_NONE  = 2'd0;
  localparam logic [1:0] AB_3     = 2'd1;
  localparam logic [1:0] AB_4     = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [10:0]      POLL_LIMIT = 11'(POLL_MAX);

  state_t                  state;
  logic [2:0]              op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             len_q;
  logic                    addr4b_q;
  logic [10:0]             poll_cnt;
  logic [GAP_W-1:0]        gap_cnt;

  logic [7:0]              status_now;
  logic [10:0]             poll_next;
  logic [7:0]              op_opcode;
  logic [1:0]              op_data_lanes;
  logic [1:0]              op_addr_bytes;
  logic [31:0]             op_len;
  logic                    rx_unused;

  assign dbg_state = state;
  assign rx_unused = ^eng_rx_data[31:8];

  // A status word arriving with eng_done is the one that decides the poll.
  assign status_now = eng_rx_wen ? eng_rx_data[7:0] : cmpl_status;
  assign poll_next  = (poll_cnt == 11'h7ff) ? poll_cnt : poll_cnt + 11'd1;

  always_comb begin
    op_opcode     = OPC_PP;
    op_data_lanes = LANE_X1;
    op_addr_bytes = addr4b_q ? AB_4 : AB_3;
    op_len        = len_q;
    case (op_q)
      3'd1: begin
        op_opcode     = OPC_PP4;
        op_data_lanes = LANE_X4;
      end
      3'd2: begin
        op_opcode = OPC_SE;
        op_len    = 32'd0;
      end
      3'd3: begin
        op_opcode = OPC_BE;
        op_len    = 32'd0;
      end
      3'd4: begin
        op_opcode     = OPC_CE;
        op_len        = 32'd0;
        op_addr_bytes = AB_NONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      cmpl_valid     <= 1'b0;
      cmpl_err       <= ERR_OK;
      cmpl_status    <= 8'h00;
      eng_start      <= 1'b0;
      eng_opcode     <= 8'h00;
      eng_cmd_lanes  <= 2'd0;
      eng_addr_lanes <= 2'd0;
      eng_data_lanes <= 2'd0;
      eng_addr_bytes <= 2'd0;
      eng_dir        <= 1'b0;
      eng_len        <= 32'd0;
      eng_addr       <= '0;
      op_q           <= 3'd0;
      addr_q         <= '0;
      len_q          <= 32'd0;
      addr4b_q       <= 1'b0;
      poll_cnt       <= 11'd0;
      gap_cnt        <= '0;
    end else begin
      eng_start  <= 1'b0;
      cmpl_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            len_q     <= req_len;
            addr4b_q  <= req_addr4b;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            if (req_op > 3'd4) begin
              cmpl_err <= ERR_ILLEGAL;
              state    <= S_DONE;
            end else begin
              cmpl_err <= ERR_OK;
              state    <= S_WREN_GO;
            end
          end
        end

        S_WREN_GO: begin
          eng_opcode     <= OPC_WREN;
          eng_cmd_lanes  <= LANE_X1;
          eng_addr_lanes <= LANE_X1;
          eng_data_lanes <= LANE_X1;
          eng_addr_bytes <= AB_NONE;
          eng_dir        <= 1'b0;
          eng_len        <= 32'd0;
          eng_addr       <= '0;
          eng_start      <= 1'b1;
          state          <= S_WREN_WAIT;
        end

        S_WREN_WAIT: begin
          if (eng_done) state <= S_OP_GO;
        end

        S_OP_GO: begin
          eng_opcode     <= op_opcode;
          eng_cmd_lanes  <= LANE_X1;
          eng_addr_lanes <= LANE_X1;
          eng_data_lanes <= op_data_lanes;
          eng_addr_bytes <= op_addr_bytes;
          eng_dir        <= 1'b0;
          eng_len        <= op_len;
          eng_addr       <= addr_q;
          eng_start      <= 1'b1;
          state          <= S_OP_WAIT;
        end

        S_OP_WAIT: begin
          if (eng_done) begin
            poll_cnt <= 11'd0;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_POLL_GO;
          else gap_cnt <= gap_cnt + 1'b1;
        end

        S_POLL_GO: begin
          eng_opcode     <= OPC_RDSR;
          eng_cmd_lanes  <= LANE_X1;
          eng_addr_lanes <= LANE_X1;
          eng_data_lanes <= LANE_X1;
          eng_addr_bytes <= AB_NONE;
          eng_dir        <= 1'b1;
          eng_len        <= 32'd4;
          eng_addr       <= '0;
          eng_start      <= 1'b1;
          state          <= S_POLL_WAIT;
        end

        S_POLL_WAIT: begin
          if (eng_rx_wen) cmpl_status <= eng_rx_data[7:0];
          if (eng_done) begin
            if (!status_now[0]) begin
              cmpl_err <= ERR_OK;
              state    <= S_DONE;
            end else begin
              poll_cnt <= poll_next;
              if (poll_next >= POLL_LIMIT) begin
                cmpl_err <= ERR_TIMEOUT;
                state    <= S_DONE;
              end else begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end
            end
          end
        end

        // req_ready rises one cycle after the completion pulse, from IDLE.
        S_DONE: begin
          cmpl_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_op_sequencer.sv
// Bench for qspi_flash_op_sequencer: engine stub with scoreboard, directed
// table, hand-written corner sequences and randomized ops against a model.
module tb_qspi_flash_op_sequencer;

  localparam int AW = 32;
  localparam int PM = 4;
  localparam int GC = 16;

  logic          clk;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_len;
  logic          req_addr4b;
  logic          busy;
  logic          cmpl_valid;
  logic [1:0]    cmpl_err;
  logic [7:0]    cmpl_status;
  logic          eng_start;
  logic          eng_done;
  logic [7:0]    eng_opcode;
  logic [1:0]    eng_cmd_lanes;
  logic [1:0]    eng_addr_lanes;
  logic [1:0]    eng_data_lanes;
  logic [1:0]    eng_addr_bytes;
  logic          eng_dir;
  logic [31:0]   eng_len;
  logic [AW-1:0] eng_addr;
  logic [31:0]   eng_rx_data;
  logic          eng_rx_wen;
  logic [3:0]    dbg_state;

  qspi_flash_op_sequencer #(.ADDR_WIDTH(AW), .POLL_MAX(PM), .GAP_CYCLES(GC)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_len(req_len), .req_addr4b(req_addr4b),
    .busy(busy), .cmpl_valid(cmpl_valid), .cmpl_err(cmpl_err), .cmpl_status(cmpl_status),
    .eng_start(eng_start), .eng_done(eng_done), .eng_opcode(eng_opcode),
    .eng_cmd_lanes(eng_cmd_lanes), .eng_addr_lanes(eng_addr_lanes),
    .eng_data_lanes(eng_data_lanes), .eng_addr_bytes(eng_addr_bytes),
    .eng_dir(eng_dir), .eng_len(eng_len), .eng_addr(eng_addr),
    .eng_rx_data(eng_rx_data), .eng_rx_wen(eng_rx_wen), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [80:0] exp_q[$];
  logic [9:0]  poll_q[$];   // {mode, status} per poll, consumed in order
  int          model_idx = 0;
  int          stub_idx = 0;
  int          start_cnt = 0;
  int          done_cyc = 0;
  logic [7:0]  model_status = 8'h00;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [80:0] txn(input logic [7:0] opc, input logic [1:0] cl, input logic [1:0] al,
                                      input logic [1:0] dl, input logic [1:0] ab, input logic dir,
                                      input logic [31:0] len, input logic [31:0] addr);
    return {opc, cl, al, dl, ab, dir, len, (ab == 2'd0) ? 32'h0 : addr};
  endfunction

  task automatic clear_sb();
    exp_q.delete();
    poll_q.delete();
    model_idx = 0;
    stub_idx = 0;
  endtask

  // Reference model: the flash command sequence and outcome for one request.
  task automatic prep_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] len,
                         input logic a4, output logic [1:0] err, output logic [7:0] stat,
                         output int starts);
    logic [7:0] opc;
    logic [1:0] dl;
    logic [1:0] ab;
    logic [31:0] l;
    logic [9:0] ent;
    int n;
    if (op > 3'd4) begin
      err = 2'd2;
      stat = model_status;
      starts = 0;
      return;
    end
    exp_q.push_back(txn(8'h06, 0, 0, 0, 0, 0, 0, 0));
    dl = 2'd0;
    ab = a4 ? 2'd2 : 2'd1;
    l = 32'd0;
    case (op)
      3'd0: begin opc = 8'h02; l = len; end
      3'd1: begin opc = 8'h38; l = len; dl = 2'd2; end
      3'd2: opc = 8'h20;
      3'd3: opc = 8'hD8;
      default: begin opc = 8'h60; ab = 2'd0; end
    endcase
    exp_q.push_back(txn(opc, 0, 0, dl, ab, 0, l, addr));
    n = 0;
    err = 2'd0;
    forever begin
      ent = (model_idx < poll_q.size()) ? poll_q[model_idx] : 10'h0;
      model_idx++;
      exp_q.push_back(txn(8'h05, 0, 0, 0, 0, 1, 32'd4, 0));
      if (ent[9:8] != 2'd3) model_status = ent[7:0];
      n++;
      if (!model_status[0]) begin err = 2'd0; break; end
      if (n == PM) begin err = 2'd1; break; end
    end
    stat = model_status;
    starts = 2 + n;
  endtask

  // ---------------- engine stub ----------------
  initial begin : engine_stub
    logic [80:0] obs;
    logic [9:0]  ent;
    logic [31:0] d;
    int lat;
    eng_done = 1'b0;
    eng_rx_wen = 1'b0;
    eng_rx_data = 32'h0;
    forever begin
      @(negedge clk);
      if (eng_start && resetn) begin
        start_cnt++;
        obs = txn(eng_opcode, eng_cmd_lanes, eng_addr_lanes, eng_data_lanes, eng_addr_bytes,
                  eng_dir, eng_len, eng_addr);
        if (exp_q.size() == 0) check("unexpected_start", obs, 81'h0);
        else check("txn", obs, exp_q.pop_front());
        if (eng_dir) check("poll_gap_ok", (cyc - done_cyc - 1) >= GC, 1);
        lat = $urandom_range(1, 3);
        repeat (lat) @(posedge clk);
        #1;
        if (eng_dir) begin
          ent = (stub_idx < poll_q.size()) ? poll_q[stub_idx] : 10'h0;
          stub_idx++;
          d = $urandom;
          d[7:0] = ent[7:0];
          case (ent[9:8])
            2'd0: begin
              eng_rx_wen = 1'b1; eng_rx_data = d;
              @(posedge clk); #1;
              eng_rx_wen = 1'b0;
            end
            2'd1: begin
              eng_rx_wen = 1'b1; eng_rx_data = d;
            end
            2'd2: begin
              eng_rx_wen = 1'b1; eng_rx_data = $urandom;
              @(posedge clk); #1;
              eng_rx_data = d;
              @(posedge clk); #1;
              eng_rx_wen = 1'b0;
            end
            default: ;
          endcase
        end
        eng_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk); #1;
        eng_done = 1'b0;
        eng_rx_wen = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] len, input logic a4, input logic [1:0] e_err,
                        input logic [7:0] e_stat, input int e_starts);
    int s0;
    bit ok;
    s0 = start_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_len = len; req_addr4b = a4;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({name, "_accept"}, ok, 1);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmpl_valid) begin ok = 1; break; end
    end
    check({name, "_cmpl_seen"}, ok, 1);
    check({name, "_err"}, cmpl_err, e_err);
    check({name, "_status"}, cmpl_status, e_stat);
    check({name, "_busy_at_cmpl"}, busy, 0);
    @(negedge clk);
    check({name, "_cmpl_one_cycle"}, cmpl_valid, 0);
    repeat (6) @(negedge clk);
    check({name, "_starts"}, start_cnt - s0, e_starts);
    check({name, "_txn_left"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] len;
    logic        a4;
    int          nst;
    logic [39:0] st;
    logic [1:0]  exp_err;
    logic [7:0]  exp_stat;
    int          exp_starts;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int k);
    logic [1:0] me;
    logic [7:0] ms;
    int mn;
    clear_sb();
    for (int i = 0; i < vecs[k].nst; i++) poll_q.push_back({2'd0, vecs[k].st[8*i +: 8]});
    prep_op(vecs[k].op, vecs[k].addr, vecs[k].len, vecs[k].a4, me, ms, mn);
    run_op($sformatf("vec%0d", k), vecs[k].op, vecs[k].addr, vecs[k].len, vecs[k].a4,
           vecs[k].exp_err, vecs[k].exp_stat, vecs[k].exp_starts);
  endtask

  // ---------------- main test ----------------
  initial begin : main
    logic [1:0] me;
    logic [7:0] ms;
    int mn;
    int s0;
    int cnt_a;
    int cnt_b;
    bit ok;

    vecs[0] = '{3'd2, 32'h0001_2345, 32'd0,   1'b0, 1, 40'h00,         2'd0, 8'h00, 3};
    vecs[1] = '{3'd1, 32'h0010_0000, 32'd256, 1'b1, 3, 40'h00_03_03,   2'd0, 8'h00, 5};
    vecs[2] = '{3'd4, 32'h0000_0000, 32'd0,   1'b0, 4, 40'h01_01_01_01, 2'd1, 8'h01, 6};
    vecs[3] = '{3'd6, 32'h0000_0040, 32'd0,   1'b0, 0, 40'h00,         2'd2, 8'h01, 0};
    vecs[4] = '{3'd0, 32'h00AB_CDEF, 32'd17,  1'b0, 2, 40'h00_01,      2'd0, 8'h00, 4};
    vecs[5] = '{3'd3, 32'h1234_5678, 32'd0,   1'b1, 1, 40'hFE,         2'd0, 8'hFE, 3};
    vecs[6] = '{3'd7, 32'h0000_0000, 32'd9,   1'b1, 0, 40'h00,         2'd2, 8'hFE, 0};
    vecs[7] = '{3'd5, 32'h0000_0100, 32'd0,   1'b0, 0, 40'h00,         2'd2, 8'hFE, 0};

    resetn = 1'b0;
    req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_len = 32'd0; req_addr4b = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cmpl_valid", cmpl_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_cmpl_err", cmpl_err, 0);
    check("rst_cmpl_status", cmpl_status, 0);
    check("rst_eng_fields", {eng_opcode, eng_cmd_lanes, eng_addr_lanes, eng_data_lanes,
                             eng_addr_bytes, eng_dir, eng_len, eng_addr}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) run_vec(k);

    // Illegal op timing: completion two cycles after the accept cycle.
    clear_sb();
    s0 = start_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd6;
    @(negedge clk);
    check("ill_ready_at_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("ill_c1_cmpl", cmpl_valid, 0);
    check("ill_c1_busy", busy, 1);
    @(negedge clk);
    check("ill_c2_cmpl", cmpl_valid, 1);
    check("ill_c2_busy", busy, 0);
    check("ill_c2_err", cmpl_err, 2);
    check("ill_c2_ready", req_ready, 0);
    @(negedge clk);
    check("ill_c3_cmpl", cmpl_valid, 0);
    check("ill_c3_ready", req_ready, 1);
    check("ill_no_start", start_cnt - s0, 0);

    // Asynchronous reset while a BE waits on its OP transaction.
    clear_sb();
    prep_op(3'd3, 32'h00AB_CD00, 32'd0, 1'b1, me, ms, mn);
    s0 = start_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd3; req_addr = 32'h00AB_CD00; req_addr4b = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstop_accept", ok, 1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (start_cnt - s0 == 2) begin ok = 1; break; end
    end
    check("rstop_op_started", ok, 1);
    resetn = 1'b0;
    #1;
    check("rstop_busy", busy, 0);
    check("rstop_ready", req_ready, 1);
    check("rstop_eng_start", eng_start, 0);
    check("rstop_cmpl", cmpl_valid, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    clear_sb();
    model_status = 8'h00;
    cnt_a = 0; cnt_b = 0;
    s0 = start_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmpl_valid) cnt_a++;
    end
    cnt_b = start_cnt - s0;
    check("rstop_no_cmpl_after", cnt_a, 0);
    check("rstop_no_start_after", cnt_b, 0);
    run_vec(0);

    // req_valid held high while busy: second accept only once req_ready returns.
    clear_sb();
    poll_q.push_back({2'd0, 8'h00});
    poll_q.push_back({2'd0, 8'h00});
    prep_op(3'd2, 32'h0000_1000, 32'd0, 1'b0, me, ms, mn);
    prep_op(3'd2, 32'h0000_1000, 32'd0, 1'b0, me, ms, mn);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h0000_1000; req_addr4b = 1'b0;
    begin
      int acc;
      int cmpl;
      int c1;
      int a2;
      int acc_at_c1;
      acc = 0; cmpl = 0; c1 = 0; a2 = 0; acc_at_c1 = 0; ok = 0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (cmpl_valid) begin
          cmpl++;
          if (cmpl == 1) begin c1 = cyc; acc_at_c1 = acc; end
          if (cmpl == 2) begin ok = 1; break; end
        end
        if (req_valid && req_ready) begin
          acc++;
          if (acc == 2) begin
            a2 = cyc;
            @(posedge clk); #1;
            req_valid = 1'b0;
          end
        end
      end
      check("hold_both_done", ok, 1);
      check("hold_accepts_before_cmpl", acc_at_c1, 1);
      check("hold_accepts_total", acc, 2);
      check("hold_second_accept_cycle", a2 - c1, 1);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("hold_txn_left", exp_q.size(), 0);

    // Randomized requests against the model.
    for (int r = 0; r < 12; r++) begin
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] len;
      logic        a4;
      int          np;
      clear_sb();
      op = 3'($urandom_range(0, 5));
      if (op == 3'd5) op = 3'($urandom_range(5, 7));
      addr = $urandom;
      len = $urandom_range(1, 512);
      a4 = 1'($urandom_range(0, 1));
      np = $urandom_range(1, 6);
      for (int i = 0; i < np; i++) begin
        logic [7:0] s;
        s = 8'($urandom_range(0, 255));
        s[0] = (i != np - 1);
        poll_q.push_back({2'($urandom_range(0, 3)), s});
      end
      prep_op(op, addr, len, a4, me, ms, mn);
      run_op($sformatf("rnd%0d", r), op, addr, len, a4, me, ms, mn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
